rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one N-bit downstream channel between four producers.
- Uses the existing 4-to-1 mux as its datapath, steered by the registered grant decision.
- Registered output stage with valid/ready handshakes on both sides; one transfer per cycle sustained.
- Sits in front of shared resources such as a memory or writeback port, which accept one transaction per cycle from several sources.

Parameters:
- N, 32, data width of each requester and of the output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  4  per-requester valid; bit i is requester i.
- req_data0..req_data3  input  N each  requester payloads.
- req_ready  output  4  combinational, at most one bit high; bit i high means requester i's beat is consumed this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  N  registered payload.
- out_src  output  2  index of the requester that supplied out_data.
- out_ready  input  1  downstream consumes the beat when out_valid && out_ready.
- stat_clr  input  1  clears grant counters (used only with the optional feature).
- stat_count  output  32  four 8-bit grant counters, requester i in bits [8i+7:8i].

Behaviour:
- Reset (rst=1 at edge):
  - out_valid=0, out_data=0, out_src=0.
  - Priority pointer ptr=0; counters=0.
  - req_ready forced 0 while rst is high.
  - A held beat is discarded.
- load_en = !out_valid || out_ready (register empty or draining this cycle).
- Pick:
  - Scan req_valid starting at index ptr, ascending, wrapping 3->0.
  - The first set bit is g; any_req = |req_valid.
- Accept when load_en && any_req:
  - req_ready[g]=1 (combinational, same cycle); all other bits 0.
  - At the edge: out_data<=req_data[g] via mux, out_src<=g, out_valid<=1, ptr<=(g+1) mod 4.
- load_en && !any_req: out_valid<=0; out_data/out_src hold their values (don't-care).
- !load_en (stalled): all registers hold; req_ready=0.
- Simultaneous drain and load is legal; throughput is 1 beat/cycle.
- Latency: accept cycle T, out_valid visible from T+1.
- Requesters hold valid and data stable until they see ready. A lower-priority requester is not starved: ptr only advances past a granted index.
- ptr is unchanged on cycles without an accept.
- Two-state FSM on out_valid:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain with no accept.
  - FULL -> FULL on drain with accept, or on stall.

Optional Feature:
- Macro: RR_ARB_STATS_EN.
- Defined:
  - Per-requester 8-bit grant counter increments on each accept of that requester.
  - Counter saturates at 255.
  - stat_clr=1 zeroes all counters at the edge; clear wins over a same-cycle increment.
- Undefined:
  - stat_count is tied to 0 and stat_clr is ignored.
  - No counter flops are instantiated; the port list is unchanged.

Decomposition:
- Package arb_pkg:
  - localparam NUM_REQ=4, STAT_W=8.
  - typedef logic [1:0] req_id_t.
  - typedef enum {ARB_EMPTY, ARB_FULL} arb_state_t.
- Sub-module rr_pick4 (combinational): inputs req_valid[3:0] and ptr; outputs g (req_id_t) and any_req. Implemented by rotate, fixed-priority encode, then un-rotate.
- Existing mux4 instantiated for the data path with s=g.

Test Plan:
- Reset mid-stream: out_valid=1 holding 0xAAAA_0001, assert rst one cycle -> next cycle out_valid=0, out_data=0, ptr=0, req_ready=0 during reset.
- Round-robin fairness: all four valid continuously, out_ready=1, data0..3=0x10..0x13 -> out_src sequence 0,1,2,3,0,... and out_data 0x10,0x11,0x12,0x13,0x10; one beat per cycle.
- Wrap with sparse requests: ptr=3 (after granting 2), req_valid=4'b0011 -> grant 0, then ptr=1 -> grant 1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with req_valid=4'b1111 -> req_ready=0 throughout, out_data stable. out_ready=1 -> drain and accept in the same cycle.
- Idle drain: single beat from requester 2 (0xDEAD_BEEF), then req_valid=0 with out_ready=1 -> out_valid falls after one cycle; ptr=3 retained.
- RR_ARB_STATS_EN: 300 grants to requester 1 -> stat_count[15:8]=255. stat_clr coincident with a grant -> counter=0 next cycle. Without the macro -> stat_count=0 always.

Source files
------------

// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int STAT_W  = 8;

  typedef logic [1:0] req_id_t;

  typedef enum logic {
    ARB_EMPTY,
    ARB_FULL
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter4_if.sv
// Requester and downstream handshake bundle for rr_arbiter4.
// master: the producers/consumer side; slave: the arbiter itself.
interface rr_arbiter4_if
  import arb_pkg::*;
#(
  parameter int N = 32
);

  logic [NUM_REQ-1:0] req_valid;
  logic [N-1:0]       req_data0;
  logic [N-1:0]       req_data1;
  logic [N-1:0]       req_data2;
  logic [N-1:0]       req_data3;
  logic [NUM_REQ-1:0] req_ready;
  logic               out_valid;
  logic [N-1:0]       out_data;
  req_id_t            out_src;
  logic               out_ready;

  modport master (
    output req_valid, req_data0, req_data1, req_data2, req_data3, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  req_valid, req_data0, req_data1, req_data2, req_data3, out_ready,
    output req_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/mux4.sv
// Generic 4-to-1 multiplexer, W bits wide, select s.
module mux4 #(
  parameter int W = 32
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   s,
  output logic [W-1:0] y
);

  // Select one of the four inputs.
  always_comb begin
    unique case (s)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
    endcase
  end

endmodule

// File: rtl/rr_arbiter4_pick.sv
// rr_pick4: combinational round-robin picker. Rotates the request vector so
// the pointer slot sits at bit 0, picks the lowest set bit, then rotates the
// index back.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  req_id_t            ptr_i,
  output req_id_t            g_o,
  output logic               any_req_o
);

  logic [NUM_REQ-1:0] rot;
  req_id_t            first;

  // Rotate, fixed-priority encode (lowest index wins), un-rotate.
  always_comb begin
    rot   = '0;
    first = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req_valid_i[req_id_t'(i) + ptr_i];
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) first = req_id_t'(i);
    end
    g_o       = first + ptr_i;
    any_req_o = |req_valid_i;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with a registered output
// stage. A beat is accepted whenever the output register is empty or
// draining, the grant pointer moves just past the winner, and the payload
// goes through mux4 steered by the grant.
// Optional grant statistics are enabled with macro RR_ARB_STATS_EN.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  rr_arbiter4_if.slave              bus,
  input  logic                      stat_clr,
  output logic [NUM_REQ*STAT_W-1:0] stat_count
);

  arb_state_t         state_q, state_d;
  req_id_t            ptr_q, ptr_d;
  logic [N-1:0]       out_data_q, out_data_d;
  req_id_t            out_src_q, out_src_d;

  req_id_t            g;
  logic               any_req;
  logic               load_en;
  logic               accept;
  logic [N-1:0]       mux_y;

  rr_pick4 u_pick (
    .req_valid_i (bus.req_valid),
    .ptr_i       (ptr_q),
    .g_o         (g),
    .any_req_o   (any_req)
  );

  mux4 #(.W(N)) u_mux (
    .d0 (bus.req_data0),
    .d1 (bus.req_data1),
    .d2 (bus.req_data2),
    .d3 (bus.req_data3),
    .s  (g),
    .y  (mux_y)
  );

  // Accept decision, one-hot ready, and next state of FSM and payload.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;

    load_en = (state_q == ARB_EMPTY) || bus.out_ready;
    accept  = !rst && load_en && any_req;

    unique case (state_q)
      ARB_EMPTY: if (accept) state_d = ARB_FULL;
      ARB_FULL:  if (bus.out_ready && !accept) state_d = ARB_EMPTY;
    endcase

    if (accept) begin
      ptr_d      = g + req_id_t'(1);
      out_data_d = mux_y;
      out_src_d  = g;
    end
  end

  // State, pointer and output register update with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples the pre-edge values together.
    if (rst) begin
      state_q    <= ARB_EMPTY;
      ptr_q      <= '0;
      out_data_q <= '0;
      out_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
    end
  end

  assign bus.req_ready = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << g) : '0;
  assign bus.out_valid = (state_q == ARB_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

`ifdef RR_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_REQ];
  logic [STAT_W-1:0] cnt_d [NUM_REQ];

  // Saturating per-requester grant counters; clear beats increment.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr) begin
        cnt_d[i] = '0;
      end else if (accept && (g == req_id_t'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    // NOTE: this small array is reset because its contents are visible on a
    // port; wide data storage would normally be left unreset.
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Pack the counters, requester i in byte i.
  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_count[i*STAT_W +: STAT_W] = cnt_q[i];
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios plus a randomized
// run, all checked against a cycle-level behavioural model of the arbiter.
module tb_rr_arbiter4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stat_clr;
  logic [31:0] stat_count;

  always #5 clk = ~clk;

  rr_arbiter4_if #(.N(32)) bus ();

  rr_arbiter4 #(.N(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .stat_clr   (stat_clr),
    .stat_count (stat_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic [31:0] din [4];
  bit          m_valid;
  logic [31:0] m_data;
  int          m_src;
  int          m_ptr;
  int          m_cnt [4];
  logic [3:0]  exp_ready, obs_ready;

`ifdef RR_ARB_STATS_EN
  localparam logic [31:0] EXP_SAT = 32'h0000_FF00;
  localparam logic [31:0] EXP_ONE = 32'h0000_0100;
`else
  localparam logic [31:0] EXP_SAT = 32'h0;
  localparam logic [31:0] EXP_ONE = 32'h0;
`endif

  // First requester at or after p, wrapping; -1 if none.
  function automatic int pick(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    if (rst) return 4'b0;
    if (m_valid && !bus.out_ready) return 4'b0;
    g = pick(bus.req_valid, m_ptr);
    if (g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  function automatic logic [31:0] model_stat();
    logic [31:0] s = 32'h0;
`ifdef RR_ARB_STATS_EN
    for (int i = 0; i < 4; i++) s[i*8 +: 8] = 8'(m_cnt[i]);
`endif
    return s;
  endfunction

  task automatic model_edge();
    int g;
    if (rst) begin
      m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      if (stat_clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      if (!m_valid || bus.out_ready) begin
        g = pick(bus.req_valid, m_ptr);
        if (g >= 0) begin
          m_valid = 1; m_data = din[g]; m_src = g; m_ptr = (g + 1) % 4;
          if (!stat_clr && m_cnt[g] < 255) m_cnt[g]++;
        end else begin
          m_valid = 0;
        end
      end
    end
  endtask

  task automatic set_data(input logic [31:0] a, b, c, d);
    din[0] = a; din[1] = b; din[2] = c; din[3] = d;
    bus.req_data0 = a; bus.req_data1 = b; bus.req_data2 = c; bus.req_data3 = d;
  endtask

  // One clock: drive at negedge, sample ready before the edge, advance model,
  // leave the caller 1 time unit after the edge to sample registered outputs.
  task automatic cycle(input logic [3:0] v, input logic ord, input logic clr,
                       input logic r);
    @(negedge clk);
    bus.req_valid = v; bus.out_ready = ord; stat_clr = clr; rst = r;
    #1;
    exp_ready = model_ready();
    obs_ready = bus.req_ready;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_src !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h src=%0d, need 0/0/0",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    set_data(32'hAAAA_0001, 32'h1, 32'h2, 32'h3);
    cycle(4'b0001, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hAAAA_0001) begin
      n_fail++;
      $display("FAIL reset_preload: valid=%b data=%h, need 1/aaaa0001",
               bus.out_valid, bus.out_data);
    end
    cycle(4'b1111, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (obs_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b need 0000", obs_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_src !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_midstream: valid=%b data=%h src=%0d, need 0/0/0",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_ready !== 4'b0001 || bus.out_src !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ptr: ready=%b src=%0d, need 0001/0", obs_ready, bus.out_src);
    end
  endtask

  task automatic test_fairness();
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    set_data(32'h10, 32'h11, 32'h12, 32'h13);
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs_ready !== 4'(1 << (i % 4)) || bus.out_valid !== 1'b1 ||
          bus.out_src !== 2'(i % 4) || bus.out_data !== 32'(16 + i % 4) ||
          obs_ready !== exp_ready || bus.out_data !== m_data) begin
        n_fail++;
        $display("FAIL fairness[%0d]: ready=%b valid=%b src=%0d data=%h, need %b/1/%0d/%h",
                 i, obs_ready, bus.out_valid, bus.out_src, bus.out_data,
                 4'(1 << (i % 4)), i % 4, 32'(16 + i % 4));
      end
    end
  endtask

  task automatic test_wrap();
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_src !== 2'd2) begin
      n_fail++;
      $display("FAIL wrap_first: src=%0d need 2", bus.out_src);
    end
    cycle(4'b0011, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_ready !== 4'b0001 || bus.out_src !== 2'd0 || bus.out_data !== 32'hA0) begin
      n_fail++;
      $display("FAIL wrap_to0: ready=%b src=%0d data=%h, need 0001/0/a0",
               obs_ready, bus.out_src, bus.out_data);
    end
    cycle(4'b0011, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_ready !== 4'b0010 || bus.out_src !== 2'd1 || bus.out_data !== 32'hA1) begin
      n_fail++;
      $display("FAIL wrap_to1: ready=%b src=%0d data=%h, need 0010/1/a1",
               obs_ready, bus.out_src, bus.out_data);
    end
  endtask

  task automatic test_backpressure();
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    set_data(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs_ready !== 4'b0001 || bus.out_valid !== 1'b1 || bus.out_data !== 32'hB0) begin
      n_fail++;
      $display("FAIL bp_load: ready=%b valid=%b data=%h, need 0001/1/b0",
               obs_ready, bus.out_valid, bus.out_data);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs_ready !== 4'b0000 || bus.out_valid !== 1'b1 ||
          bus.out_data !== 32'hB0 || bus.out_src !== 2'd0) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: ready=%b valid=%b data=%h src=%0d, need 0000/1/b0/0",
                 i, obs_ready, bus.out_valid, bus.out_data, bus.out_src);
      end
    end
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_ready !== 4'b0010 || bus.out_valid !== 1'b1 ||
        bus.out_data !== 32'hB1 || bus.out_src !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_release: ready=%b valid=%b data=%h src=%0d, need 0010/1/b1/1",
               obs_ready, bus.out_valid, bus.out_data, bus.out_src);
    end
  endtask

  task automatic test_idle_drain();
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    set_data(32'h0, 32'h1, 32'hDEAD_BEEF, 32'h3);
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEAD_BEEF || bus.out_src !== 2'd2) begin
      n_fail++;
      $display("FAIL drain_load: valid=%b data=%h src=%0d, need 1/deadbeef/2",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || obs_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL drain_idle: valid=%b ready=%b, need 0/0000", bus.out_valid, obs_ready);
    end
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_ready !== 4'b1000 || bus.out_src !== 2'd3) begin
      n_fail++;
      $display("FAIL drain_ptr: ready=%b src=%0d, need 1000/3", obs_ready, bus.out_src);
    end
  endtask

  task automatic test_random();
    logic [3:0] pend;
    logic       ord, clr;
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    pend = 4'b0;
    for (int i = 0; i < 4; i++) din[i] = $urandom();
    for (int n = 0; n < 400; n++) begin
      // Requesters hold valid and data until granted.
      for (int i = 0; i < 4; i++) begin
        if (!pend[i]) begin
          pend[i] = ($urandom_range(0, 2) != 0);
          din[i]  = $urandom();
        end
      end
      set_data(din[0], din[1], din[2], din[3]);
      ord = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      cycle(pend, ord, clr, 1'b0);
      n_checks++;
      if (obs_ready !== exp_ready || bus.out_valid !== m_valid ||
          bus.out_data !== m_data || bus.out_src !== 2'(m_src) ||
          stat_count !== model_stat()) begin
        n_fail++;
        $display("FAIL random[%0d]: ready=%b/%b valid=%b/%b data=%h/%h src=%0d/%0d stat=%h/%h",
                 n, obs_ready, exp_ready, bus.out_valid, m_valid, bus.out_data, m_data,
                 bus.out_src, m_src, stat_count, model_stat());
      end
      pend = pend & ~exp_ready;
    end
  endtask

  task automatic test_stats();
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    set_data(32'h0, 32'h5, 32'h0, 32'h0);
    for (int n = 0; n < 300; n++) begin
      cycle(4'b0010, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (stat_count !== model_stat()) begin
        n_fail++;
        $display("FAIL stats_count[%0d]: got %h need %h", n, stat_count, model_stat());
      end
    end
    n_checks++;
    if (stat_count !== EXP_SAT) begin
      n_fail++;
      $display("FAIL stats_saturate: got %h need %h", stat_count, EXP_SAT);
    end
    cycle(4'b0010, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (stat_count !== 32'h0) begin
      n_fail++;
      $display("FAIL stats_clear_wins: got %h need 0", stat_count);
    end
    cycle(4'b0010, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (stat_count !== EXP_ONE) begin
      n_fail++;
      $display("FAIL stats_after_clear: got %h need %h", stat_count, EXP_ONE);
    end
  endtask

  initial begin
    rst = 1'b1;
    stat_clr = 1'b0;
    bus.req_valid = 4'b0;
    bus.out_ready = 1'b0;
    set_data(32'h0, 32'h0, 32'h0, 32'h0);
    m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;

    test_reset();
    test_fairness();
    test_wrap();
    test_backpressure();
    test_idle_drain();
    test_random();
    test_stats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
